// File: rtl/par_univ_reg_sync_rstn.sv
// Multi-mode WIDTH-bit register: hold / load / toggle / set / clear /
// shift left / shift right / add-accumulate, selected per cycle by mode.
package par_univ_reg_pkg;
  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_TGL  = 3'b010,
    OP_SET  = 3'b011,
    OP_CLR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_ADD  = 3'b111
  } op_e;
endpackage

// One bit lane: next-state for every bitwise and shift op. ADD needs the
// carry chain, so the top overrides the lane result in that mode.
module par_univ_reg_lane
  import par_univ_reg_pkg::*;
(
  input  op_e  op,
  input  logic q_bit,
  input  logic d_bit,
  input  logic lo_bit,   // bit below (or sin for bit 0) feeds SHL
  input  logic hi_bit,   // bit above (or sin for top bit) feeds SHR
  output logic nxt
);
  // Per-bit next value
  always_comb begin
    nxt = q_bit;
    case (op)
      OP_HOLD: nxt = q_bit;
      OP_LOAD: nxt = d_bit;
      OP_TGL:  nxt = q_bit ^ d_bit;
      OP_SET:  nxt = q_bit | d_bit;
      OP_CLR:  nxt = q_bit & ~d_bit;
      OP_SHL:  nxt = lo_bit;
      OP_SHR:  nxt = hi_bit;
      default: nxt = q_bit;
    endcase
  end
endmodule

module par_univ_reg_sync_rstn
  import par_univ_reg_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout,
  output logic             carry,
  output logic             zero
);
  localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

  op_e              op;
  logic [WIDTH-1:0] lane_nxt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;
  logic             carry_nxt;

  assign op  = op_e'(mode);
  assign sum = {1'b0, q} + {1'b0, d};

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic lo, hi;
    if (i == 0) begin : g_lo_sin
      assign lo = sin;
    end else begin : g_lo_q
      assign lo = q[i-1];
    end
    if (i == WIDTH-1) begin : g_hi_sin
      assign hi = sin;
    end else begin : g_hi_q
      assign hi = q[i+1];
    end
    par_univ_reg_lane u_lane (
      .op    (op),
      .q_bit (q[i]),
      .d_bit (d[i]),
      .lo_bit(lo),
      .hi_bit(hi),
      .nxt   (lane_nxt[i])
    );
  end

  // Select next state; sout and carry are sticky outside their own ops
  always_comb begin
    q_nxt     = lane_nxt;
    sout_nxt  = sout;
    carry_nxt = carry;
    case (op)
      OP_SHL: sout_nxt = q[WIDTH-1];
      OP_SHR: sout_nxt = q[0];
      OP_ADD: begin
        q_nxt     = sum[WIDTH-1:0];
        carry_nxt = sum[WIDTH];
      end
      default: ;
    endcase
  end

  // State register: sync reset wins over enable and mode
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q     <= RST_Q;
      sout  <= 1'b0;
      carry <= 1'b0;
    end else if (en) begin
      q     <= q_nxt;
      sout  <= sout_nxt;
      carry <= carry_nxt;
    end
  end

  assign qbar = ~q;
  assign zero = (q == '0);
endmodule

// File: tb/tb_par_univ_reg_sync_rstn.sv
// Directed bench: instance a resets to A5, instance b resets to 00.
module tb_par_univ_reg_sync_rstn;
  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, TGL = 3'd2, SET = 3'd3,
                         CLR  = 3'd4, SHL  = 3'd5, SHR = 3'd6, ADD = 3'd7;

  logic       clk = 0;
  logic       rstn, en, sin;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] q_a, qbar_a, q_b, qbar_b;
  logic       sout_a, carry_a, zero_a, sout_b, carry_b, zero_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  par_univ_reg_sync_rstn #(.WIDTH(8), .RST_VAL(32'hA5)) u_a (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q_a), .qbar(qbar_a), .sout(sout_a), .carry(carry_a), .zero(zero_a)
  );

  par_univ_reg_sync_rstn #(.WIDTH(8), .RST_VAL(32'h0)) u_b (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q_b), .qbar(qbar_b), .sout(sout_b), .carry(carry_b), .zero(zero_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // apply one op and sample 1ns after the edge
  task automatic op(input logic r, input logic e, input logic [2:0] m,
                    input logic [7:0] dv, input logic s);
    rstn = r; en = e; mode = m; d = dv; sin = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 0; en = 0; mode = HOLD; d = 0; sin = 0;
    #2;

    // reset overrides en/LOAD
    op(0, 1, LOAD, 8'hFF, 0);
    chk("rst_q",     q_a, 8'hA5);
    chk("rst_qbar",  qbar_a, 8'h5A);
    chk("rst_sout",  sout_a, 0);
    chk("rst_carry", carry_a, 0);
    chk("rst_zero",  zero_a, 0);
    chk("rst0_q",    q_b, 8'h00);
    chk("rst0_qbar", qbar_b, 8'hFF);
    chk("rst0_zero", zero_b, 1);

    // enable and bitwise ops
    op(1, 0, LOAD, 8'h3C, 0); chk("en0_hold", q_a, 8'hA5);
    op(1, 1, LOAD, 8'h3C, 0); chk("load",     q_a, 8'h3C);
    chk("load_b", q_b, 8'h3C);
    op(1, 1, TGL,  8'h0F, 0); chk("toggle",   q_a, 8'h33);
    op(1, 1, SET,  8'h80, 0); chk("set",      q_a, 8'hB3);
    op(1, 1, CLR,  8'h03, 0); chk("clr",      q_a, 8'hB0);
    chk("clr_qbar", qbar_a, 8'h4F);
    op(1, 1, HOLD, 8'hFF, 1); chk("hold",     q_a, 8'hB0);

    // shifts
    op(1, 1, LOAD, 8'h81, 0);
    op(1, 1, SHL,  8'h00, 0); chk("shl_q", q_a, 8'h02); chk("shl_sout", sout_a, 1);
    op(1, 1, SHR,  8'h00, 1); chk("shr_q", q_a, 8'h81); chk("shr_sout", sout_a, 0);

    // sticky sout
    op(1, 1, SHL,  8'h00, 0); chk("shl2_sout", sout_a, 1);
    op(1, 1, LOAD, 8'h55, 0); chk("stk_load_q", q_a, 8'h55); chk("stk_load_sout", sout_a, 1);
    op(1, 1, TGL,  8'hFF, 0); chk("stk_tgl_q", q_a, 8'hAA);  chk("stk_tgl_sout", sout_a, 1);
    op(1, 1, ADD,  8'h01, 0); chk("stk_add_q", q_a, 8'hAB);  chk("stk_add_sout", sout_a, 1);

    // fill with ones
    op(1, 1, LOAD, 8'h00, 0); chk("fill_start_zero", zero_a, 1);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'((9'd1 << (i + 1)) - 9'd1);
      op(1, 1, SHL, 8'h00, 1);
      chk($sformatf("fill_q%0d", i), q_a, e);
      chk($sformatf("fill_zero%0d", i), zero_a, 0);
    end

    // arithmetic wrap and sticky carry
    op(1, 1, LOAD, 8'hF0, 0);
    op(1, 1, ADD,  8'h20, 0); chk("add_ovf_q", q_a, 8'h10); chk("add_ovf_c", carry_a, 1);
    op(1, 1, HOLD, 8'h00, 0); chk("stk_hold_c", carry_a, 1);
    op(1, 1, SHL,  8'h00, 0); chk("stk_shl_q", q_a, 8'h20); chk("stk_shl_c", carry_a, 1);
    op(1, 1, SHR,  8'h00, 0); chk("stk_shr_q", q_a, 8'h10); chk("stk_shr_c", carry_a, 1);
    op(1, 1, ADD,  8'h01, 0); chk("add_q", q_a, 8'h11); chk("add_c", carry_a, 0);
    op(1, 1, LOAD, 8'h00, 0); chk("ld0_c", carry_a, 0); chk("ld0_zero", zero_a, 1);
    op(1, 1, LOAD, 8'hFF, 0);
    op(1, 1, ADD,  8'h01, 0); chk("wrap_q", q_a, 8'h00); chk("wrap_c", carry_a, 1);
    chk("wrap_zero", zero_a, 1);
    op(1, 0, ADD,  8'h01, 0); chk("en0_add_q", q_a, 8'h00); chk("en0_add_c", carry_a, 1);

    // reset in the middle of an ADD run
    op(1, 1, LOAD, 8'h80, 0);
    op(1, 1, SHL,  8'h00, 0); chk("pre_sout", sout_a, 1);
    op(1, 1, LOAD, 8'hFE, 0);
    op(1, 1, ADD,  8'h01, 0); chk("run1_q", q_a, 8'hFF);
    op(1, 1, ADD,  8'h01, 0); chk("run2_q", q_a, 8'h00); chk("run2_c", carry_a, 1);
    op(0, 1, ADD,  8'h01, 0); chk("mid_rst_q", q_a, 8'hA5); chk("mid_rst_c", carry_a, 0);
    chk("mid_rst_sout", sout_a, 0); chk("mid_rst_qb", q_b, 8'h00);
    op(1, 1, ADD,  8'h01, 0); chk("resume_q", q_a, 8'hA6); chk("resume_c", carry_a, 0);
    chk("resume_qb", q_b, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
